// File: rtl/dual_fetch_queue_if.sv
// Fetch-stage bus: decode/redirect control, imem ports and the two decode slots.
interface dual_fetch_queue_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              fetch_stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [1:0]        deq_count;
    logic [ADDR_W-1:0] address_imem_1;
    logic [ADDR_W-1:0] address_imem_2;
    logic [DATA_W-1:0] q_imem_1;
    logic [DATA_W-1:0] q_imem_2;
    logic              out_valid_1;
    logic [DATA_W-1:0] out_instr_1;
    logic [ADDR_W-1:0] out_pc_1;
    logic              out_valid_2;
    logic [DATA_W-1:0] out_instr_2;
    logic [ADDR_W-1:0] out_pc_2;
    logic [CNT_W-1:0]  q_count;

    // Environment side: decode, branch unit and instruction memory
    modport master (
        output fetch_stall, redirect_valid, redirect_pc, deq_count, q_imem_1, q_imem_2,
        input  address_imem_1, address_imem_2, out_valid_1, out_instr_1, out_pc_1,
               out_valid_2, out_instr_2, out_pc_2, q_count
    );

    // Fetch queue side
    modport slave (
        input  fetch_stall, redirect_valid, redirect_pc, deq_count, q_imem_1, q_imem_2,
        output address_imem_1, address_imem_2, out_valid_1, out_instr_1, out_pc_1,
               out_valid_2, out_instr_2, out_pc_2, q_count
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch queue: fetches PC pairs, buffers them in a circular queue
// and presents the two oldest entries to decode. Redirects flush everything.
module dual_fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input logic              clock,
    input logic              reset,
    dual_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_nxt;
    logic [PTR_W-1:0]  tail_nxt;
    logic [CNT_W-1:0]  count;
    logic              enq;
    logic [1:0]        deq_req;
    logic [1:0]        deq_eff;

    assign head_nxt = head + PTR_W'(1);
    assign tail_nxt = tail + PTR_W'(1);

    // Per-cycle enqueue/dequeue decision; room is judged before this cycle's dequeue
    always_comb begin
        deq_req = (bus.deq_count == 2'd3) ? 2'd2 : bus.deq_count;
        deq_eff = (CNT_W'(deq_req) > count) ? count[1:0] : deq_req;
        enq     = !bus.redirect_valid && !bus.fetch_stall && (count <= CNT_W'(DEPTH - 2));
    end

    // Control state: fetch PC, queue pointers and occupancy; redirect wins over all
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            head  <= head + PTR_W'(deq_eff);
            count <= count + (enq ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq_eff);
            if (enq) begin
                fetch_pc <= fetch_pc + ADDR_W'(2);
                tail     <= tail + PTR_W'(2);
            end
        end
    end

    // Entry storage: always written as a pair; stale contents are masked by count
    always_ff @(posedge clock) begin
        if (enq) begin
            entries[tail]     <= '{instr: bus.q_imem_1, pc: fetch_pc};
            entries[tail_nxt] <= '{instr: bus.q_imem_2, pc: fetch_pc + ADDR_W'(1)};
        end
    end

    assign bus.address_imem_1 = fetch_pc;
    assign bus.address_imem_2 = fetch_pc + ADDR_W'(1);
    assign bus.q_count        = count;

    // Decode slots are zeroed (nop, PC 0) whenever they hold nothing
    always_comb begin
        bus.out_valid_1 = (count >= CNT_W'(1));
        bus.out_valid_2 = (count >= CNT_W'(2));
        bus.out_instr_1 = bus.out_valid_1 ? entries[head].instr     : '0;
        bus.out_pc_1    = bus.out_valid_1 ? entries[head].pc        : '0;
        bus.out_instr_2 = bus.out_valid_2 ? entries[head_nxt].instr : '0;
        bus.out_pc_2    = bus.out_valid_2 ? entries[head_nxt].pc    : '0;
    end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// Bench for dual_fetch_queue: directed scenarios then random traffic, all
// checked against a queue-based reference model of the fetch stage.
module tb_dual_fetch_queue;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int MASK   = (1 << ADDR_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    dual_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dual_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clock = ~clock;

    typedef struct {
        int pc;
        int instr;
    } ent_t;

    ent_t mq[$];
    int   mpc;
    int   errors = 0;
    int   checks = 0;

    // Instruction memory contents: imem[k] = k + 100
    function automatic int imem(input int a);
        return a + 100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the model
    task automatic check_all(input string ctx);
        int n;
        int p1, i1, p2, i2;
        n  = mq.size();
        p1 = 0; i1 = 0; p2 = 0; i2 = 0;
        if (n >= 1) begin p1 = mq[0].pc; i1 = mq[0].instr; end
        if (n >= 2) begin p2 = mq[1].pc; i2 = mq[1].instr; end
        chk({ctx, ":q_count"}, 32'(bus.q_count), 32'(n));
        chk({ctx, ":valid1"},  32'(bus.out_valid_1), 32'(n >= 1));
        chk({ctx, ":valid2"},  32'(bus.out_valid_2), 32'(n >= 2));
        chk({ctx, ":pc1"},     32'(bus.out_pc_1), 32'(p1));
        chk({ctx, ":instr1"},  bus.out_instr_1, 32'(i1));
        chk({ctx, ":pc2"},     32'(bus.out_pc_2), 32'(p2));
        chk({ctx, ":instr2"},  bus.out_instr_2, 32'(i2));
        chk({ctx, ":addr1"},   32'(bus.address_imem_1), 32'(mpc));
        chk({ctx, ":addr2"},   32'(bus.address_imem_2), 32'((mpc + 1) & MASK));
    endtask

    // One clock: drive inputs and imem data, advance the model, check after the edge
    task automatic cycle(input bit stall, input bit rv, input int rpc, input int deq);
        int d;
        int free;
        bus.fetch_stall    = stall;
        bus.redirect_valid = rv;
        bus.redirect_pc    = ADDR_W'(rpc);
        bus.deq_count      = 2'(deq);
        bus.q_imem_1       = 32'(imem(int'(bus.address_imem_1)));
        bus.q_imem_2       = 32'(imem(int'(bus.address_imem_2)));
        if (rv) begin
            mq.delete();
            mpc = rpc & MASK;
        end else begin
            d = (deq > 2) ? 2 : deq;
            if (d > mq.size()) d = mq.size();
            free = DEPTH - mq.size();
            repeat (d) void'(mq.pop_front());
            if (!stall && free >= 2) begin
                mq.push_back('{mpc, imem(mpc)});
                mq.push_back('{(mpc + 1) & MASK, imem((mpc + 1) & MASK)});
                mpc = (mpc + 2) & MASK;
            end
        end
        @(posedge clock);
        @(negedge clock);
        check_all("cyc");
    endtask

    // Asynchronous reset pulse away from the rising edge
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        mq.delete();
        mpc = 0;
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Stimulus sequence
    initial begin
        bus.fetch_stall    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_count      = 2'd0;
        bus.q_imem_1       = '0;
        bus.q_imem_2       = '0;
        mpc                = 0;
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b1;

        // Fill to full, then hold
        repeat (4) cycle(1'b0, 1'b0, 0, 0);
        chk("fill_count", 32'(bus.q_count), 32'd8);
        chk("fill_instr1", bus.out_instr_1, 32'd100);
        chk("fill_instr2", bus.out_instr_2, 32'd101);
        repeat (2) cycle(1'b0, 1'b0, 0, 0);
        chk("full_hold_pc", 32'(bus.address_imem_1), 32'd8);

        // Single dequeue from full
        cycle(1'b0, 1'b0, 0, 1);
        chk("deq1_pc1", 32'(bus.out_pc_1), 32'd1);
        chk("deq1_pc2", 32'(bus.out_pc_2), 32'd2);
        chk("deq1_count", 32'(bus.q_count), 32'd7);
        cycle(1'b0, 1'b0, 0, 1);

        // Steady dual dequeue
        repeat (8) cycle(1'b0, 1'b0, 0, 2);
        chk("steady_count", 32'(bus.q_count), 32'd6);

        // Redirect with simultaneous dequeue
        cycle(1'b0, 1'b1, 40, 2);
        chk("redir_count", 32'(bus.q_count), 32'd0);
        chk("redir_addr", 32'(bus.address_imem_1), 32'd40);
        cycle(1'b0, 1'b0, 0, 0);
        chk("redir_pc1", 32'(bus.out_pc_1), 32'd40);
        chk("redir_pc2", 32'(bus.out_pc_2), 32'd41);

        // PC wrap-around
        cycle(1'b0, 1'b1, 4095, 0);
        chk("wrap_addr2", 32'(bus.address_imem_2), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 0, 0);
        chk("wrap_pc1", 32'(bus.out_pc_1), 32'd4095);
        chk("wrap_pc2", 32'(bus.out_pc_2), 32'd0);
        cycle(1'b0, 1'b0, 0, 2);
        chk("wrap_next_pc1", 32'(bus.out_pc_1), 32'd1);
        chk("wrap_next_pc2", 32'(bus.out_pc_2), 32'd2);

        // Reset mid-stream, then resume from PC 0
        async_reset();
        cycle(1'b0, 1'b0, 0, 0);
        chk("resume_pc1", 32'(bus.out_pc_1), 32'd0);

        // Stall while decode drains one per cycle
        repeat (2) cycle(1'b0, 1'b0, 0, 0);
        repeat (3) cycle(1'b1, 1'b0, 0, 1);
        chk("stall_count", 32'(bus.q_count), 32'd3);
        chk("stall_pc", 32'(bus.address_imem_1), 32'd6);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            bit st, rv;
            int rpc;
            st  = ($urandom_range(0, 4) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(4090, 4095))
                                              : int'($urandom_range(0, 4095));
            if ($urandom_range(0, 149) == 0) async_reset();
            cycle(st, rv, rpc, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
